ram_request_responder: RTL and testbench

RAM-side end of the cache/RAM FIFO link. Pops line requests that the cache-side controller has pushed into the request FIFO and executes each one against a single-port synchronous SRAM as a 4-word burst. For reads, it pushes the 4 read words into the response FIFO that the cache side drains. Exactly one request is in progress at a time.

---
 rtl/ram_request_responder_pkg.sv | 39 +++
 rtl/ram_request_responder.sv | 185 ++++++++++++++++++
 tb/tb_ram_request_responder.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_request_responder_pkg.sv
// rtl/ram_request_responder_pkg.sv - shared constants and types for the cache/RAM FIFO link
//
// Purpose: state encoding of the RAM-side responder, burst geometry and the
// request-entry field layout. The cache-side controller packs entries with
// the same field positions, so both ends agree on the bit layout.
//
// Contents:
//   state_t         responder FSM states
//   WORDS_PER_LINE  words per cache line (burst length)
//   RQ_*            request-entry field positions for the default geometry
//   is_last_word()  true when a burst index addresses the final word
package ram_request_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_DATA  = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_LATCH = 3'd3,
        ST_RD_PUSH  = 3'd4
    } state_t;

    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_IDX_W     = 2;

    localparam int DEF_ADDR_SIZE  = 13;
    localparam int DEF_WORD_WIDTH = 16;
    localparam int DEF_RQ_WIDTH   = 2 + DEF_ADDR_SIZE + DEF_WORD_WIDTH;

    // Entry layout, MSB first: avalid | rnw | line address | data word.
    localparam int RQ_DATA_LSB   = 0;
    localparam int RQ_ADDR_LSB   = RQ_DATA_LSB + DEF_WORD_WIDTH;
    localparam int RQ_RNW_BIT    = RQ_ADDR_LSB + DEF_ADDR_SIZE;
    localparam int RQ_AVALID_BIT = RQ_RNW_BIT + 1;

    function automatic logic is_last_word(input logic [LINE_IDX_W-1:0] i);
        return i == LINE_IDX_W'(WORDS_PER_LINE - 1);
    endfunction

endpackage

// File: rtl/ram_request_responder.sv
// rtl/ram_request_responder.sv - RAM-side executor of cache line requests
//
// Purpose: pops line requests from the request FIFO and runs each one as a
// 4-word burst against a single-port synchronous SRAM. Read words are pushed
// into the response FIFO, LSW first. One request is in flight at a time.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   rq_empty, rq_dout   request FIFO status and first-word-fall-through head
//   rq_rd               pop request FIFO head
//   rs_full             response FIFO full
//   rs_wr, rs_din       push read word into response FIFO
//   ram_en, ram_we      SRAM access strobe and write enable
//   ram_a, ram_wd       SRAM word address {line, idx} and write data
//   ram_rd              SRAM read data, one cycle after a read access
//   busy                responder is not idle
//   err_orphan          continuation entry seen while idle (dropped)
//   err_trunc           write burst cut short by a new request
module ram_request_responder
    import ram_request_responder_pkg::*;
#(
    parameter int ADDR_SIZE  = 13,
    parameter int WORD_WIDTH = 16,
    parameter int RQ_WIDTH   = 2 + ADDR_SIZE + WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rq_empty,
    input  logic [RQ_WIDTH-1:0]   rq_dout,
    output logic                  rq_rd,
    input  logic                  rs_full,
    output logic                  rs_wr,
    output logic [WORD_WIDTH-1:0] rs_din,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_SIZE+1:0]  ram_a,
    output logic [WORD_WIDTH-1:0] ram_wd,
    input  logic [WORD_WIDTH-1:0] ram_rd,
    output logic                  busy,
    output logic                  err_orphan,
    output logic                  err_trunc
);

    // Field positions follow the parameters so non-default geometries still
    // decode correctly; for the defaults they equal the package RQ_* values.
    localparam int AVALID_POS = RQ_WIDTH - 1;
    localparam int RNW_POS    = RQ_WIDTH - 2;
    localparam int ADDR_LSB   = WORD_WIDTH;

    state_t                  state, state_n;
    logic [ADDR_SIZE-1:0]    line, line_n;
    logic [LINE_IDX_W-1:0]   idx, idx_n;
    logic [WORD_WIDTH-1:0]   hold, hold_n;

    logic                    head_avalid;
    logic                    head_rnw;
    logic [ADDR_SIZE-1:0]    head_addr;
    logic [WORD_WIDTH-1:0]   head_data;

    logic                    rq_rd_c, rs_wr_c, ram_en_c, ram_we_c;
    logic [WORD_WIDTH-1:0]   rs_din_c, ram_wd_c;
    logic [ADDR_SIZE+1:0]    ram_a_c;
    logic                    orphan_c, trunc_c;

    assign head_avalid = rq_dout[AVALID_POS];
    assign head_rnw    = rq_dout[RNW_POS];
    assign head_addr   = rq_dout[ADDR_LSB +: ADDR_SIZE];
    assign head_data   = rq_dout[RQ_DATA_LSB +: WORD_WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            line  <= '0;
            idx   <= '0;
            hold  <= '0;
        end else begin
            state <= state_n;
            line  <= line_n;
            idx   <= idx_n;
            hold  <= hold_n;
        end
    end

    always_comb begin
        state_n  = state;
        line_n   = line;
        idx_n    = idx;
        hold_n   = hold;
        rq_rd_c  = 1'b0;
        rs_wr_c  = 1'b0;
        rs_din_c = '0;
        ram_en_c = 1'b0;
        ram_we_c = 1'b0;
        ram_a_c  = '0;
        ram_wd_c = '0;
        orphan_c = 1'b0;
        trunc_c  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (!rq_empty) begin
                    rq_rd_c = 1'b1;
                    if (!head_avalid) begin
                        // Continuation word with no burst open: drop it.
                        orphan_c = 1'b1;
                    end else if (head_rnw) begin
                        line_n  = head_addr;
                        idx_n   = '0;
                        state_n = ST_RD_ISSUE;
                    end else begin
                        // The head entry of a write already carries word 0,
                        // so it is written in the same cycle it is popped.
                        ram_en_c = 1'b1;
                        ram_we_c = 1'b1;
                        ram_a_c  = {head_addr, 2'd0};
                        ram_wd_c = head_data;
                        line_n   = head_addr;
                        idx_n    = 2'd1;
                        state_n  = ST_WR_DATA;
                    end
                end
            end

            ST_WR_DATA: begin
                if (!rq_empty) begin
                    if (!head_avalid) begin
                        rq_rd_c  = 1'b1;
                        ram_en_c = 1'b1;
                        ram_we_c = 1'b1;
                        ram_a_c  = {line, idx};
                        ram_wd_c = head_data;
                        idx_n    = idx + 2'd1;
                        if (is_last_word(idx)) begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        // A new request arrived mid-burst: abandon the write
                        // and leave the head for IDLE to process.
                        trunc_c = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
            end

            ST_RD_ISSUE: begin
                ram_en_c = 1'b1;
                ram_a_c  = {line, idx};
                state_n  = ST_RD_LATCH;
            end

            ST_RD_LATCH: begin
                // Capture the word so backpressure in RD_PUSH cannot lose it.
                hold_n  = ram_rd;
                state_n = ST_RD_PUSH;
            end

            ST_RD_PUSH: begin
                if (!rs_full) begin
                    rs_wr_c  = 1'b1;
                    rs_din_c = hold;
                    idx_n    = idx + 2'd1;
                    state_n  = is_last_word(idx) ? ST_IDLE : ST_RD_ISSUE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Every output is forced low while reset is asserted, including the
    // cycle in which reset rises mid-burst.
    assign rq_rd      = rq_rd_c  & ~reset;
    assign rs_wr      = rs_wr_c  & ~reset;
    assign rs_din     = reset ? '0 : rs_din_c;
    assign ram_en     = ram_en_c & ~reset;
    assign ram_we     = ram_we_c & ~reset;
    assign ram_a      = reset ? '0 : ram_a_c;
    assign ram_wd     = reset ? '0 : ram_wd_c;
    assign busy       = (state != ST_IDLE) & ~reset;
    assign err_orphan = orphan_c & ~reset;
    assign err_trunc  = trunc_c  & ~reset;

endmodule

// File: tb/tb_ram_request_responder.sv
// tb/tb_ram_request_responder.sv - directed self-checking bench for ram_request_responder
module tb_ram_request_responder;
    import ram_request_responder_pkg::*;

    logic        clk;
    logic        reset;
    logic        rq_empty;
    logic [30:0] rq_dout;
    logic        rq_rd;
    logic        rs_full;
    logic        rs_wr;
    logic [15:0] rs_din;
    logic        ram_en;
    logic        ram_we;
    logic [14:0] ram_a;
    logic [15:0] ram_wd;
    logic [15:0] ram_rd;
    logic        busy;
    logic        err_orphan;
    logic        err_trunc;

    ram_request_responder dut (
        .clk(clk), .reset(reset),
        .rq_empty(rq_empty), .rq_dout(rq_dout), .rq_rd(rq_rd),
        .rs_full(rs_full), .rs_wr(rs_wr), .rs_din(rs_din),
        .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_wd(ram_wd),
        .ram_rd(ram_rd), .busy(busy),
        .err_orphan(err_orphan), .err_trunc(err_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rd_when_empty = 0;
    int wr_when_full  = 0;
    int last_busy_cyc = -1;

    logic [30:0] rq_q[$];
    logic [15:0] mem [0:32767];
    int          pop_cyc[$];
    int          push_cyc[$];
    logic [15:0] push_data[$];
    int          wr_cyc[$];
    logic [14:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int          acc_cyc[$];
    int          orphan_cyc[$];
    int          trunc_cyc[$];

    function automatic logic [30:0] ent(input bit av, input bit rnw,
                                         input logic [12:0] a, input logic [15:0] d);
        logic [30:0] e;
        e = '0;
        e[RQ_AVALID_BIT] = av;
        e[RQ_RNW_BIT]    = rnw;
        e[RQ_ADDR_LSB +: 13] = a;
        e[RQ_DATA_LSB +: 16] = d;
        return e;
    endfunction

    // FIFO + SRAM model. Outputs are sampled 2 time units after the falling
    // edge and stamped with the index of the rising edge that commits them;
    // the committed effects are applied 1 unit after that rising edge.
    initial begin
        bit          p_pop, p_en, p_we;
        logic [14:0] p_a;
        logic [15:0] p_wd;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[4] = 16'hC001; mem[5] = 16'hC002; mem[6] = 16'hC003; mem[7] = 16'hC004;
        ram_rd = '0; rq_empty = 1'b1; rq_dout = '0;
        p_pop = 0; p_en = 0; p_we = 0; p_a = '0; p_wd = '0;
        forever begin
            @(negedge clk);
            #1;
            rq_empty = (rq_q.size() == 0);
            rq_dout  = (rq_q.size() != 0) ? rq_q[0] : '0;
            #1;
            if (rq_rd) begin
                if (rq_empty) rd_when_empty++;
                pop_cyc.push_back(cyc);
                p_pop = 1;
            end
            if (rs_wr) begin
                if (rs_full) wr_when_full++;
                push_cyc.push_back(cyc);
                push_data.push_back(rs_din);
            end
            if (ram_en) begin
                acc_cyc.push_back(cyc);
                p_en = 1; p_we = ram_we; p_a = ram_a; p_wd = ram_wd;
                if (ram_we) begin
                    wr_cyc.push_back(cyc); wr_addr.push_back(ram_a); wr_data.push_back(ram_wd);
                end
            end
            if (busy) last_busy_cyc = cyc;
            if (err_orphan) orphan_cyc.push_back(cyc);
            if (err_trunc) trunc_cyc.push_back(cyc);
            @(posedge clk);
            #1;
            cyc++;
            if (p_pop && rq_q.size() != 0) void'(rq_q.pop_front());
            if (p_en) begin
                if (p_we) mem[p_a] = p_wd;
                else      ram_rd = mem[p_a];
            end
            p_pop = 0; p_en = 0;
            rq_empty = (rq_q.size() == 0);
            rq_dout  = (rq_q.size() != 0) ? rq_q[0] : '0;
        end
    end

    task automatic clear_logs();
        pop_cyc.delete(); push_cyc.delete(); push_data.delete();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        acc_cyc.delete(); orphan_cyc.delete(); trunc_cyc.delete();
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        @(negedge clk); @(negedge clk);
        while ((rq_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 300);
    endtask

    task automatic wait_pop(output int t);
        int n;
        n = 0;
        while (pop_cyc.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        t = (pop_cyc.size() != 0) ? pop_cyc[0] : -1000;
    endtask

    task automatic test_reset();
        rq_q.push_back(ent(1, 1, 13'h0A5, 16'h0));
        repeat (2) @(negedge clk);
        #3;
        n_checks++;
        if ({rq_rd, rs_wr, rs_din, ram_en, ram_we, ram_a, ram_wd, busy, err_orphan, err_trunc} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rq_rd=%b ram_en=%b busy=%b, want all 0", rq_rd, ram_en, busy);
        end
        rq_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #3;
        n_checks++;
        if (busy !== 1'b0 || rq_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b rq_rd=%b, want 0 0", busy, rq_rd);
        end
        n_checks++;
        if (pop_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL reset_no_pop: got %0d pops, want 0", pop_cyc.size());
        end
    endtask

    task automatic test_write_burst();
        bit ok;
        logic [15:0] exp_d [4];
        exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333; exp_d[3] = 16'h4444;
        clear_logs();
        @(negedge clk);
        rq_q.push_back(ent(1, 0, 13'h0A5, 16'h1111));
        rq_q.push_back(ent(0, 0, 13'h0, 16'h2222));
        rq_q.push_back(ent(0, 0, 13'h0, 16'h3333));
        rq_q.push_back(ent(0, 0, 13'h0, 16'h4444));
        wait_idle(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL wr_timeout: responder still busy"); end
        n_checks++;
        if (wr_addr.size() != 4 || pop_cyc.size() != 4) begin
            n_fail++;
            $display("FAIL wr_count: got %0d writes %0d pops, want 4 4", wr_addr.size(), pop_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wr_addr[i] !== 15'h294 + 15'(i) || wr_data[i] !== exp_d[i] ||
                    wr_cyc[i] != wr_cyc[0] + i || pop_cyc[i] != wr_cyc[i]) begin
                    n_fail++;
                    $display("FAIL wr_word%0d: got a=%h d=%h cyc=%0d, want a=%h d=%h cyc=%0d",
                             i, wr_addr[i], wr_data[i], wr_cyc[i], 15'h294 + 15'(i), exp_d[i], wr_cyc[0] + i);
                end
            end
            n_checks++;
            if (last_busy_cyc != wr_cyc[3]) begin
                n_fail++;
                $display("FAIL wr_busy_fall: last busy cycle %0d, want %0d", last_busy_cyc, wr_cyc[3]);
            end
        end
    endtask

    task automatic test_read_burst();
        bit ok;
        logic [15:0] exp_d [4];
        exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333; exp_d[3] = 16'h4444;
        clear_logs();
        @(negedge clk);
        rq_q.push_back(ent(1, 1, 13'h0A5, 16'h0));
        wait_idle(ok);
        n_checks++;
        if (!ok || push_data.size() != 4 || pop_cyc.size() != 1 || wr_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL rd_count: got %0d pushes %0d pops %0d writes, want 4 1 0",
                     push_data.size(), pop_cyc.size(), wr_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (push_data[i] !== exp_d[i] || push_cyc[i] != pop_cyc[0] + 3 + 3 * i) begin
                    n_fail++;
                    $display("FAIL rd_word%0d: got d=%h cyc=%0d, want d=%h cyc=%0d",
                             i, push_data[i], push_cyc[i], exp_d[i], pop_cyc[0] + 3 + 3 * i);
                end
            end
        end
    endtask

    task automatic test_read_backpressure();
        bit ok;
        int t;
        int n;
        int exp_c [4];
        logic [15:0] exp_d [4];
        exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333; exp_d[3] = 16'h4444;
        clear_logs();
        @(negedge clk);
        rq_q.push_back(ent(1, 1, 13'h0A5, 16'h0));
        wait_pop(t);
        n = 0;
        while (cyc < t + 6 && n < 50) begin @(negedge clk); n++; end
        rs_full = 1'b1;
        repeat (5) @(negedge clk);
        rs_full = 1'b0;
        wait_idle(ok);
        exp_c[0] = t + 3; exp_c[1] = t + 11; exp_c[2] = t + 14; exp_c[3] = t + 17;
        n_checks++;
        if (!ok || push_data.size() != 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d pushes, want 4", push_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (push_data[i] !== exp_d[i] || push_cyc[i] != exp_c[i]) begin
                    n_fail++;
                    $display("FAIL bp_word%0d: got d=%h cyc=%0d, want d=%h cyc=%0d",
                             i, push_data[i], push_cyc[i], exp_d[i], exp_c[i]);
                end
            end
        end
    endtask

    task automatic test_write_trunc();
        bit ok;
        logic [15:0] exp_d [4];
        exp_d[0] = 16'hC001; exp_d[1] = 16'hC002; exp_d[2] = 16'hC003; exp_d[3] = 16'hC004;
        clear_logs();
        @(negedge clk);
        rq_q.push_back(ent(1, 0, 13'h0A5, 16'hAAAA));
        rq_q.push_back(ent(1, 1, 13'h001, 16'h0));
        wait_idle(ok);
        n_checks++;
        if (!ok || wr_cyc.size() != 1 || trunc_cyc.size() != 1 || pop_cyc.size() != 2) begin
            n_fail++;
            $display("FAIL tr_count: got %0d writes %0d truncs %0d pops, want 1 1 2",
                     wr_cyc.size(), trunc_cyc.size(), pop_cyc.size());
        end else begin
            n_checks++;
            if (wr_addr[0] !== 15'h294 || wr_data[0] !== 16'hAAAA) begin
                n_fail++;
                $display("FAIL tr_write: got a=%h d=%h, want a=0294 d=aaaa", wr_addr[0], wr_data[0]);
            end
            n_checks++;
            if (trunc_cyc[0] != wr_cyc[0] + 1 || pop_cyc[1] != wr_cyc[0] + 2) begin
                n_fail++;
                $display("FAIL tr_timing: got trunc=%0d pop=%0d, want %0d %0d",
                         trunc_cyc[0], pop_cyc[1], wr_cyc[0] + 1, wr_cyc[0] + 2);
            end
        end
        n_checks++;
        if (mem[15'h295] !== 16'h2222) begin
            n_fail++;
            $display("FAIL tr_ram_kept: got %h, want 2222", mem[15'h295]);
        end
        n_checks++;
        if (push_data.size() != 4) begin
            n_fail++;
            $display("FAIL tr_read_count: got %0d pushes, want 4", push_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (push_data[i] !== exp_d[i]) begin
                    n_fail++;
                    $display("FAIL tr_read%0d: got %h, want %h", i, push_data[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_orphan();
        bit ok;
        clear_logs();
        @(negedge clk);
        rq_q.push_back(ent(0, 0, 13'h123, 16'hBEEF));
        wait_idle(ok);
        n_checks++;
        if (!ok || pop_cyc.size() != 1 || orphan_cyc.size() != 1 || acc_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL orphan: got %0d pops %0d pulses %0d ram accesses, want 1 1 0",
                     pop_cyc.size(), orphan_cyc.size(), acc_cyc.size());
        end else begin
            n_checks++;
            if (orphan_cyc[0] != pop_cyc[0]) begin
                n_fail++;
                $display("FAIL orphan_timing: got pulse %0d, want %0d", orphan_cyc[0], pop_cyc[0]);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        int t;
        int n;
        clear_logs();
        @(negedge clk);
        rq_q.push_back(ent(1, 1, 13'h0A5, 16'h0));
        wait_pop(t);
        n = 0;
        while (cyc < t + 5 && n < 50) begin @(negedge clk); n++; end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({rq_rd, rs_wr, rs_din, ram_en, ram_we, ram_a, ram_wd, busy, err_orphan, err_trunc} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got ram_en=%b busy=%b rs_wr=%b, want all 0", ram_en, busy, rs_wr);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #3;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: got busy=%b, want 0", busy);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (push_cyc.size() != 1 || pop_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL midrst_no_push: got %0d pushes %0d pops, want 1 1", push_cyc.size(), pop_cyc.size());
        end
        clear_logs();
        rq_q.push_back(ent(1, 1, 13'h001, 16'h0));
        wait_idle(ok);
        n_checks++;
        if (!ok || push_data.size() != 4 || push_data[0] !== 16'hC001) begin
            n_fail++;
            $display("FAIL midrst_recover: got %0d pushes, want 4 starting c001", push_data.size());
        end
    endtask

    initial begin
        reset   = 1'b1;
        rs_full = 1'b0;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_read_backpressure();
        test_write_trunc();
        test_orphan();
        test_reset_mid_read();
        n_checks++;
        if (rd_when_empty != 0 || wr_when_full != 0) begin
            n_fail++;
            $display("FAIL protocol: got %0d pops while empty %0d pushes while full, want 0 0",
                     rd_when_empty, wr_when_full);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
